// File: rtl/apc_lut_pkg.sv
// apc_lut_pkg: shared constants for the sequential APC product LUT.
// FSM state encodings and the table-depth helper used by apc_lut_mult_seq.
package apc_lut_pkg;

    // FSM states: table empty, table filling, table ready for lookups
    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_FILL  = 2'd1;
    localparam logic [1:0] ST_READY = 2'd2;

    // Number of table entries for a given address width
    function automatic int lut_depth(input int x_w);
        return (32'sd1 <<< x_w);
    endfunction

endpackage

// File: rtl/apc_lut_regfile.sv
// apc_lut_regfile: DEPTH x DW product table, one synchronous write port and
// one combinational read port. Storage is not reset; its contents are only
// meaningful after a complete fill.
module apc_lut_regfile #(
    parameter int DEPTH = 16,
    parameter int AW    = 4,
    parameter int DW    = 9
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [DEPTH];

    // Table write during fill
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/apc_lut_mult_seq.sv
// apc_lut_mult_seq: runtime-loadable APC product table with pipelined lookup.
// A coef_load captures coefficient a and fills entry k = k*a (entry 0 holds
// 2**X_W * a) by repeated addition, one entry per cycle. Lookups then pass
// through a 2-stage valid/ready pipeline (address register, then table read
// into the output register).
// Optional feature macro: APC_LUT_PARITY_EN adds an even-parity bit per
// entry and a parity_err output flagging a corrupted read.
module apc_lut_mult_seq
    import apc_lut_pkg::*;
#(
    parameter int A_W = 5,
    parameter int X_W = 4,
    parameter int P_W = A_W + X_W
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           coef_load,
    input  logic [A_W-1:0] coef,
    output logic           busy,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [X_W-1:0] x_dash,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [P_W-1:0] apc_prod
`ifdef APC_LUT_PARITY_EN
    ,
    output logic           parity_err
`endif
);

    localparam int DEPTH = lut_depth(X_W);
`ifdef APC_LUT_PARITY_EN
    localparam int RF_W = P_W + 1;

    // Even parity: stored bit makes the total number of ones even
    function automatic logic even_par(input logic [P_W-1:0] d);
        return ^d;
    endfunction
`else
    localparam int RF_W = P_W;
`endif

    logic [1:0]      state_r;
    logic [P_W-1:0]  coef_r;
    logic [P_W-1:0]  acc_r;
    logic [X_W-1:0]  cnt_r;
    logic            s1_valid_r;
    logic [X_W-1:0]  s1_x_r;

    logic            stall_s;
    logic            accept_s;
    logic            we_s;
    logic [RF_W-1:0] wdata_s;
    logic [RF_W-1:0] rdata_s;
    logic [P_W-1:0]  rd_prod_s;

    // Flow control: a stalled output freezes the whole pipeline, and a
    // coefficient reload blocks new requests in the same cycle
    always_comb begin
        stall_s  = out_valid & ~out_ready;
        in_ready = (state_r == ST_READY) & ~coef_load & ~stall_s;
        accept_s = in_valid & in_ready;
        we_s     = (state_r == ST_FILL);
    end

    // Table write data: running product, plus its parity bit when enabled
    always_comb begin
`ifdef APC_LUT_PARITY_EN
        wdata_s = {even_par(acc_r), acc_r};
`else
        wdata_s = acc_r;
`endif
        rd_prod_s = rdata_s[P_W-1:0];
    end

    apc_lut_regfile #(
        .DEPTH (DEPTH),
        .AW    (X_W),
        .DW    (RF_W)
    ) u_rf (
        .clk   (clk),
        .we    (we_s),
        .waddr (cnt_r),
        .wdata (wdata_s),
        .raddr (s1_x_r),
        .rdata (rdata_s)
    );

    // Fill FSM: cnt walks 1..DEPTH-1 then wraps to 0; acc always equals cnt*a
    // (DEPTH*a when cnt wraps to 0), so every fill cycle writes entry cnt = acc
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_EMPTY;
            busy    <= 1'b0;
            coef_r  <= {P_W{1'b0}};
            acc_r   <= {P_W{1'b0}};
            cnt_r   <= {X_W{1'b0}};
        end else if (coef_load) begin
            state_r <= ST_FILL;
            busy    <= 1'b1;
            coef_r  <= P_W'(coef);
            acc_r   <= P_W'(coef);
            cnt_r   <= X_W'(1);
        end else begin
            case (state_r)
                ST_FILL: begin
                    acc_r <= acc_r + coef_r;
                    cnt_r <= cnt_r + X_W'(1);
                    if (cnt_r == {X_W{1'b0}}) begin
                        state_r <= ST_READY;
                        busy    <= 1'b0;
                    end
                end
                ST_EMPTY, ST_READY: begin
                    busy <= 1'b0;
                end
                default: begin
                    state_r <= ST_EMPTY;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

    // Lookup pipeline: stage1 holds the address, stage2 the table product;
    // a reload flushes both so no product from the old table escapes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_r <= 1'b0;
            s1_x_r     <= {X_W{1'b0}};
            out_valid  <= 1'b0;
            apc_prod   <= {P_W{1'b0}};
`ifdef APC_LUT_PARITY_EN
            parity_err <= 1'b0;
`endif
        end else if (coef_load) begin
            s1_valid_r <= 1'b0;
            out_valid  <= 1'b0;
`ifdef APC_LUT_PARITY_EN
            parity_err <= 1'b0;
`endif
        end else if (!stall_s) begin
            s1_valid_r <= accept_s;
            s1_x_r     <= x_dash;
            out_valid  <= s1_valid_r;
            if (s1_valid_r) begin
                apc_prod <= rd_prod_s;
            end
`ifdef APC_LUT_PARITY_EN
            parity_err <= s1_valid_r & (even_par(rd_prod_s) != rdata_s[P_W]);
`endif
        end
    end

endmodule

// File: tb/tb_apc_lut_mult_seq.sv
// tb_apc_lut_mult_seq: directed bench for apc_lut_mult_seq with a
// transaction-level reference model (queue of expected products with the
// earliest cycle each may appear) checked on every falling edge.
// Optional feature macro: APC_LUT_PARITY_EN enables the parity checks.
module tb_apc_lut_mult_seq;

    localparam int A_W   = 5;
    localparam int X_W   = 4;
    localparam int P_W   = 9;
    localparam int DEPTH = 16;

    logic           clk = 1'b0;
    logic           rst_n = 1'b1;
    logic           coef_load = 1'b0;
    logic [A_W-1:0] coef = 5'd0;
    logic           busy;
    logic           in_valid = 1'b0;
    logic           in_ready;
    logic [X_W-1:0] x_dash = 4'd0;
    logic           out_valid;
    logic           out_ready = 1'b1;
    logic [P_W-1:0] apc_prod;

    // second instance with a narrow product (P_W = 6)
    logic           b_coef_load = 1'b0;
    logic [A_W-1:0] b_coef = 5'd0;
    logic           b_busy;
    logic           b_in_valid = 1'b0;
    logic           b_in_ready;
    logic [X_W-1:0] b_x = 4'd0;
    logic           b_out_valid;
    logic           b_out_ready = 1'b1;
    logic [5:0]     b_prod;
`ifdef APC_LUT_PARITY_EN
    logic           parity_err;
    logic           b_parity_err;
`endif

    apc_lut_mult_seq #(.A_W(A_W), .X_W(X_W), .P_W(P_W)) dut (
        .clk(clk), .rst_n(rst_n), .coef_load(coef_load), .coef(coef), .busy(busy),
        .in_valid(in_valid), .in_ready(in_ready), .x_dash(x_dash),
        .out_valid(out_valid), .out_ready(out_ready), .apc_prod(apc_prod)
`ifdef APC_LUT_PARITY_EN
        , .parity_err(parity_err)
`endif
    );

    apc_lut_mult_seq #(.A_W(A_W), .X_W(X_W), .P_W(6)) dut6 (
        .clk(clk), .rst_n(rst_n), .coef_load(b_coef_load), .coef(b_coef), .busy(b_busy),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .x_dash(b_x),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .apc_prod(b_prod)
`ifdef APC_LUT_PARITY_EN
        , .parity_err(b_parity_err)
`endif
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // APC product: address 0 stands for multiplier 2**X_W, result wraps at 2**pw
    function automatic logic [31:0] prod_of(input int a, input int x, input int pw);
        int m;
        m = (x == 0) ? DEPTH : x;
        return (a * m) & ((1 << pw) - 1);
    endfunction

    typedef struct {
        logic [31:0] val;
        int          rdy;
        bit          perr;
    } item_t;

    item_t q[$];
    int    cyc = 0;
    int    model_coef = 0;
    int    fill_left = 0;
    bit    loaded = 1'b0;
    int    perr_idx = -1;

    // logs of what the DUT itself did (accepts / deliveries)
    int acc_cyc[$];
    int dlv_val[$];
    int dlv_cyc[$];

    // cycle counter
    always @(posedge clk) cyc <= cyc + 1;

    // reference model + per-cycle compare; values seen at the falling edge
    // are exactly those the next rising edge will sample
    always @(negedge clk) begin
        bit    exp_valid;
        bit    exp_ready;
        item_t it;
        if (!rst_n) begin
            chk("rst_busy", busy, 0);
            chk("rst_in_ready", in_ready, 0);
            chk("rst_out_valid", out_valid, 0);
            chk("rst_prod", apc_prod, 0);
            q.delete();
            fill_left = 0;
            loaded    = 1'b0;
        end else begin
            exp_valid = (q.size() > 0) && (q[0].rdy <= cyc);
            exp_ready = loaded && (fill_left == 0) && !coef_load && !(exp_valid && !out_ready);
            chk("busy", busy, (fill_left > 0) ? 1 : 0);
            chk("in_ready", in_ready, exp_ready);
            chk("out_valid", out_valid, exp_valid);
            if (exp_valid) begin
                chk("apc_prod", apc_prod, q[0].val);
`ifdef APC_LUT_PARITY_EN
                chk("parity_err", parity_err, q[0].perr);
`endif
            end else begin
`ifdef APC_LUT_PARITY_EN
                chk("parity_err_idle", parity_err, 0);
`endif
            end
            if (out_valid && out_ready) begin
                dlv_val.push_back(int'(apc_prod));
                dlv_cyc.push_back(cyc);
            end
            if (in_valid && in_ready) acc_cyc.push_back(cyc);
            // advance the model to the state after the coming rising edge
            if (exp_valid && out_ready) begin
                void'(q.pop_front());
                if (q.size() > 0 && q[0].rdy < cyc + 1) q[0].rdy = cyc + 1;
            end
            if (fill_left > 0) fill_left--;
            if (coef_load) begin
                q.delete();
                model_coef = int'(coef);
                fill_left  = DEPTH;
                loaded     = 1'b1;
            end else if (in_valid && exp_ready) begin
                it.val  = prod_of(model_coef, int'(x_dash), P_W);
                it.rdy  = cyc + 2;
                it.perr = (int'(x_dash) == perr_idx);
                q.push_back(it);
            end
        end
    end

    bit rnd_ready = 1'b0;

    task automatic step();
        @(posedge clk);
        #1;
        if (rnd_ready) out_ready = ($urandom_range(0, 3) != 0);
    endtask

    task automatic load(input int c);
        coef_load = 1'b1;
        coef      = A_W'(c);
        step();
        coef_load = 1'b0;
    endtask

    task automatic send(input int x);
        bit ok;
        in_valid = 1'b1;
        x_dash   = X_W'(x);
        ok       = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (in_ready) ok = 1'b1;
            step();
            if (ok) break;
        end
        if (!ok) chk("send_timeout", 0, 1);
    endtask

    task automatic clear_logs();
        acc_cyc.delete();
        dlv_val.delete();
        dlv_cyc.delete();
    endtask

    initial begin
        int n;
        bit seen;

        // ---- reset
        #2 rst_n = 1'b0;
        #1;
        chk("reset_busy", busy, 0);
        chk("reset_out_valid", out_valid, 0);
        chk("reset_prod", apc_prod, 0);
        repeat (3) step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        step();

        // ---- 1: fill length
        load(5);
        n = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (!busy) break;
            n++;
        end
        chk("fill_cycles", n, 16);
        chk("ready_after_fill", in_ready, 1);
        step();

        // ---- 2: back-to-back lookups, a=5
        clear_logs();
        send(1); send(3); send(15); send(0);
        in_valid = 1'b0;
        repeat (6) step();
        chk("t2_count", dlv_val.size(), 4);
        if (dlv_val.size() == 4 && acc_cyc.size() == 4) begin
            chk("t2_p1", dlv_val[0], 5);
            chk("t2_p3", dlv_val[1], 15);
            chk("t2_p15", dlv_val[2], 75);
            chk("t2_p0", dlv_val[3], 80);
            for (int i = 0; i < 4; i++) chk("t2_latency", dlv_cyc[i] - acc_cyc[i], 2);
        end

`ifdef APC_LUT_PARITY_EN
        // corrupt the stored parity bit of entry 3; data stays 15
        perr_idx = 3;
        dut.u_rf.mem[3][P_W] = ~dut.u_rf.mem[3][P_W];
        clear_logs();
        send(3);
        in_valid = 1'b0;
        repeat (4) step();
        chk("perr_count", dlv_val.size(), 1);
        if (dlv_val.size() == 1) chk("perr_data", dlv_val[0], 15);
        perr_idx = -1;
`endif

        // ---- 3: a=31 sweep with random backpressure
        load(31);
        repeat (DEPTH + 1) step();
        clear_logs();
        rnd_ready = 1'b1;
        for (int k = 0; k < DEPTH; k++) send(k);
        in_valid  = 1'b0;
        rnd_ready = 1'b0;
        out_ready = 1'b1;
        repeat (6) step();
        chk("t3_count", dlv_val.size(), 16);
        if (dlv_val.size() == 16) begin
            chk("t3_x0", dlv_val[0], 496);
            chk("t3_x15", dlv_val[15], 465);
            for (int k = 1; k < DEPTH; k++) chk("t3_sweep", dlv_val[k], 31 * k);
        end

        // ---- 4: reload with two lookups in flight
        load(7);
        repeat (DEPTH + 1) step();
        clear_logs();
        out_ready = 1'b0;
        send(1); send(2);
        in_valid = 1'b0;
        load(3);
        @(negedge clk);
        chk("t4_flush_valid", out_valid, 0);
        chk("t4_flush_busy", busy, 1);
        step();
        out_ready = 1'b1;
        repeat (DEPTH + 1) step();
        send(2);
        in_valid = 1'b0;
        repeat (4) step();
        chk("t4_count", dlv_val.size(), 1);
        if (dlv_val.size() == 1) chk("t4_x2", dlv_val[0], 6);

        // ---- 5: reset in the middle of a fill
        load(9);
        repeat (5) step();
        #2 rst_n = 1'b0;
        #1;
        chk("t5_busy", busy, 0);
        chk("t5_in_ready", in_ready, 0);
        chk("t5_out_valid", out_valid, 0);
        chk("t5_prod", apc_prod, 0);
        step();
        rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (in_ready) seen = 1'b1;
            step();
        end
        chk("t5_ready_stays_low", seen, 0);
        load(4);
        repeat (DEPTH + 1) step();
        clear_logs();
        send(0);
        in_valid = 1'b0;
        repeat (4) step();
        chk("t5_count", dlv_val.size(), 1);
        if (dlv_val.size() == 1) chk("t5_x0", dlv_val[0], 64);

        // ---- 6: narrow product instance, a=31
        b_coef_load = 1'b1;
        b_coef      = 5'd31;
        step();
        b_coef_load = 1'b0;
        repeat (DEPTH + 1) step();
        for (int t = 0; t < 2; t++) begin
            b_x        = (t == 0) ? 4'd15 : 4'd0;
            b_in_valid = 1'b1;
            @(negedge clk);
            chk("t6_in_ready", b_in_ready, 1);
            step();
            b_in_valid = 1'b0;
            seen = 1'b0;
            for (int i = 0; i < 10; i++) begin
                @(negedge clk);
                if (b_out_valid) begin
                    seen = 1'b1;
                    chk("t6_prod", b_prod, (t == 0) ? 17 : 48);
                    break;
                end
            end
            chk("t6_seen", seen, 1);
            step();
        end

        repeat (2) step();
        chk("end_queue_empty", q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
